// File: rtl/sticker_color_sampler.sv
// sticker_color_sampler: averages the 8x8 sample window of each sticker in a
// 3x3 grid over one camera frame and stores the nine mean colours of one
// cube face into the packed 54-entry R/G/B colour tables.
// Optional feature macro: SAMPLER_TIMEOUT_EN adds a 20-bit watchdog on
// WAIT_SOF/ACCUM that pulses oERR and abandons the capture.
module sticker_color_sampler #(
    parameter int X0    = 200,
    parameter int Y0    = 120,
    parameter int PITCH = 80,
    parameter int OFF   = 36
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iFVAL,
    input  logic         iDVAL,
    input  logic [9:0]   iX,
    input  logic [9:0]   iY,
    input  logic [7:0]   iR,
    input  logic [7:0]   iG,
    input  logic [7:0]   iB,
    input  logic         iCAPTURE,
    input  logic [2:0]   iFACE,
    output logic [431:0] oColor_R,
    output logic [431:0] oColor_G,
    output logic [431:0] oColor_B,
    output logic         oBUSY,
    output logic         oDONE,
    output logic         oERR
);

    localparam int unsigned NSTK = 9;
    localparam int unsigned AW   = 14;
    localparam int unsigned WIN  = 8;
    localparam int unsigned CW   = 432;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACCUM,
        S_STORE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_fval;
    logic            r_fval_d;
    logic            w_rise;
    logic            w_fall;
    logic [2:0]      r_face;
    logic [3:0]      r_j;
    logic [5:0]      w_k;
    logic [8:0]      w_pos;
    logic [2:0]      w_col_hit;
    logic [2:0]      w_row_hit;
    logic [NSTK-1:0] w_hit;
    logic [AW-1:0]   r_acc_r [NSTK];
    logic [AW-1:0]   r_acc_g [NSTK];
    logic [AW-1:0]   r_acc_b [NSTK];
    logic [CW-1:0]   r_col_r;
    logic [CW-1:0]   r_col_g;
    logic [CW-1:0]   r_col_b;
    logic            r_busy;
    logic            r_done;
    logic            w_tmo;

    assign w_rise = r_fval & ~r_fval_d;
    assign w_fall = ~r_fval & r_fval_d;

    // Destination colour index for the current STORE cycle and its bit position
    assign w_k   = ({3'd0, r_face} * 6'd9) + {2'd0, r_j};
    assign w_pos = 9'd431 - {w_k, 3'b000};

    // Column / row window decode; windows are disjoint because OFF+8 < PITCH
    for (genvar c = 0; c < 3; c++) begin : g_win
        assign w_col_hit[c] = (iX >= 10'(X0 + c * PITCH + OFF)) &&
                              (iX <  10'(X0 + c * PITCH + OFF + int'(WIN)));
        assign w_row_hit[c] = (iY >= 10'(Y0 + c * PITCH + OFF)) &&
                              (iY <  10'(Y0 + c * PITCH + OFF + int'(WIN)));
    end

    // Per-sticker accumulators: cleared at start of frame, summed during ACCUM
    for (genvar s = 0; s < int'(NSTK); s++) begin : g_stk
        assign w_hit[s] = w_col_hit[s % 3] & w_row_hit[s / 3];

        // Accumulate this sticker's window pixels
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                r_acc_r[s] <= '0;
                r_acc_g[s] <= '0;
                r_acc_b[s] <= '0;
            end else if (r_state == S_WAIT_SOF && w_rise) begin
                r_acc_r[s] <= '0;
                r_acc_g[s] <= '0;
                r_acc_b[s] <= '0;
            end else if (r_state == S_ACCUM && iDVAL && w_hit[s]) begin
                r_acc_r[s] <= r_acc_r[s] + AW'(iR);
                r_acc_g[s] <= r_acc_g[s] + AW'(iG);
                r_acc_b[s] <= r_acc_b[s] + AW'(iB);
            end
        end
    end

    // Frame-valid edge detector
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_fval   <= 1'b0;
            r_fval_d <= 1'b0;
        end else begin
            r_fval   <= iFVAL;
            r_fval_d <= r_fval;
        end
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iCAPTURE && iFACE <= 3'd5) w_next = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (w_tmo)       w_next = S_IDLE;
                else if (w_rise) w_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_tmo)       w_next = S_IDLE;
                else if (w_fall) w_next = S_STORE;
            end
            S_STORE: begin
                if (r_j == 4'd8) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Face latch and STORE sequencing counter
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_face <= '0;
            r_j    <= '0;
        end else begin
            if (r_state == S_IDLE && w_next == S_WAIT_SOF) r_face <= iFACE;
            if (r_state == S_STORE) r_j <= r_j + 4'd1;
            else                    r_j <= '0;
        end
    end

    // Colour tables: one sticker mean (sum/64) written per STORE cycle
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_col_r <= '0;
            r_col_g <= '0;
            r_col_b <= '0;
        end else if (r_state == S_STORE) begin
            r_col_r[w_pos -: 8] <= r_acc_r[r_j][AW-1:6];
            r_col_g[w_pos -: 8] <= r_acc_g[r_j][AW-1:6];
            r_col_b[w_pos -: 8] <= r_acc_b[r_j][AW-1:6];
        end
    end

    // Registered status outputs aligned with the state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
        end
    end

`ifdef SAMPLER_TIMEOUT_EN
    localparam int unsigned TW = 20;
    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_tmo = (r_state == S_WAIT_SOF || r_state == S_ACCUM) &&
                   (r_tmo == {TW{1'b1}});

    // Watchdog: restarts on every state change, counts while waiting on the camera
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (w_next != r_state)
                r_tmo <= '0;
            else if (r_state == S_WAIT_SOF || r_state == S_ACCUM)
                r_tmo <= r_tmo + TW'(1);
        end
    end

    assign oERR = r_err;
`else
    assign w_tmo = 1'b0;
    assign oERR  = 1'b0;
`endif

    assign oColor_R = r_col_r;
    assign oColor_G = r_col_g;
    assign oColor_B = r_col_b;
    assign oBUSY    = r_busy;
    assign oDONE    = r_done;

endmodule

// File: tb/tb_sticker_color_sampler.sv
// Bench for sticker_color_sampler: table of capture requests plus hand-written
// corner sequences, checked against a division-based model of sticker windows.
module tb_sticker_color_sampler;

    localparam int X0    = 200;
    localparam int Y0    = 120;
    localparam int PITCH = 80;
    localparam int OFF   = 36;

    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic         iFVAL = 1'b0;
    logic         iDVAL = 1'b0;
    logic [9:0]   iX = '0;
    logic [9:0]   iY = '0;
    logic [7:0]   iR = '0;
    logic [7:0]   iG = '0;
    logic [7:0]   iB = '0;
    logic         iCAPTURE = 1'b0;
    logic [2:0]   iFACE = '0;
    logic [431:0] oColor_R;
    logic [431:0] oColor_G;
    logic [431:0] oColor_B;
    logic         oBUSY;
    logic         oDONE;
    logic         oERR;

    sticker_color_sampler #(.X0(X0), .Y0(Y0), .PITCH(PITCH), .OFF(OFF)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
        .iCAPTURE(iCAPTURE), .iFACE(iFACE),
        .oColor_R(oColor_R), .oColor_G(oColor_G), .oColor_B(oColor_B),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    int         m_sum [9][3];
    logic [7:0] exp_r [54];
    logic [7:0] exp_g [54];
    logic [7:0] exp_b [54];

    typedef struct {
        logic [2:0] face;
        int         kind;
        bit         accept;
    } vec_t;

    vec_t tbl [8];

    always @(negedge iCLK) if (oDONE) done_cnt++;

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1, "watchdog");
    end

    // Sticker index for a pixel, or -1 when outside every sample window
    function automatic int model_stk(input int x, input int y);
        int cx, cy, ox, oy;
        if (x < X0 || y < Y0) return -1;
        cx = (x - X0) / PITCH;
        ox = (x - X0) % PITCH;
        cy = (y - Y0) / PITCH;
        oy = (y - Y0) % PITCH;
        if (cx > 2 || cy > 2) return -1;
        if (ox < OFF || ox >= OFF + 8 || oy < OFF || oy >= OFF + 8) return -1;
        return cy * 3 + cx;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic chk_vec(input string name, input logic [431:0] act, input logic [431:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_colors(input string tag);
        logic [431:0] er, eg, eb;
        for (int k = 0; k < 54; k++) begin
            er[431-8*k -: 8] = exp_r[k];
            eg[431-8*k -: 8] = exp_g[k];
            eb[431-8*k -: 8] = exp_b[k];
        end
        chk_vec({tag, "_R"}, oColor_R, er);
        chk_vec({tag, "_G"}, oColor_G, eg);
        chk_vec({tag, "_B"}, oColor_B, eb);
    endtask

    task automatic clear_sums();
        for (int s = 0; s < 9; s++)
            for (int c = 0; c < 3; c++) m_sum[s][c] = 0;
    endtask

    task automatic commit_face(input int f);
        for (int s = 0; s < 9; s++) begin
            exp_r[f*9+s] = 8'(m_sum[s][0] / 64);
            exp_g[f*9+s] = 8'(m_sum[s][1] / 64);
            exp_b[f*9+s] = 8'(m_sum[s][2] / 64);
        end
    endtask

    task automatic drive_pix(input int x, input int y, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b,
                             input bit dv, input bit sample);
        int s;
        @(posedge iCLK); #1;
        iCAPTURE = 1'b0;
        iX = 10'(x); iY = 10'(y); iR = r; iG = g; iB = b; iDVAL = dv;
        s = model_stk(x, y);
        if (dv && sample && s >= 0) begin
            m_sum[s][0] += int'(r);
            m_sum[s][1] += int'(g);
            m_sum[s][2] += int'(b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK); #1;
            iCAPTURE = 1'b0;
            iDVAL = 1'b0;
        end
    endtask

    // kind 0: uniform 40/80/C0; kind 1: sticker 4 red only; kind 2: random
    task automatic run_frame(input int kind, input bit sample, input bit mid_en,
                             input logic [2:0] mid_face);
        int n, wx, wy, x, y;
        logic [7:0] r, g, b;
        bit dv;
        n = 0;
        @(posedge iCLK); #1;
        iFVAL = 1'b1;
        idle(4);
        for (int s = 0; s < 9; s++) begin
            wx = X0 + (s % 3) * PITCH + OFF;
            wy = Y0 + (s / 3) * PITCH + OFF;
            for (int dy = -2; dy < 10; dy++) begin
                for (int dx = -2; dx < 10; dx++) begin
                    x = wx + dx; y = wy + dy;
                    dv = 1'b1;
                    case (kind)
                        0: begin r = 8'h40; g = 8'h80; b = 8'hC0; end
                        1: begin
                            r = (model_stk(x, y) == 4) ? 8'hFF : 8'h00;
                            g = 8'h00; b = 8'h00;
                        end
                        default: begin
                            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                            dv = ($urandom % 4) != 0;
                        end
                    endcase
                    drive_pix(x, y, r, g, b, dv, sample);
                    if (mid_en && n == 300) begin
                        iCAPTURE = 1'b1;
                        iFACE = mid_face;
                    end
                    n++;
                end
            end
        end
        if (kind == 2) begin
            for (int i = 0; i < 20; i++) begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
                dv = model_stk(x, y) < 0;
                drive_pix(x, y, 8'($urandom), 8'($urandom), 8'($urandom), dv, sample);
            end
        end
        idle(4);
        iFVAL = 1'b0;
    endtask

    task automatic req(input logic [2:0] face, input bit accept, input string name);
        @(posedge iCLK); #1;
        iCAPTURE = 1'b1;
        iFACE = face;
        @(posedge iCLK); #1;
        iCAPTURE = 1'b0;
        chk({name, "_busy"}, 64'(oBUSY), 64'(accept));
    endtask

    task automatic wait_done(input bit expect_done, input bit busy_after, input string name);
        int first, d0;
        first = 0;
        d0 = done_cnt;
        for (int n = 1; n <= 20; n++) begin
            @(posedge iCLK); #1;
            if (oDONE && first == 0) first = n;
        end
        chk({name, "_latency"}, 64'(first), expect_done ? 64'd11 : 64'd0);
        chk({name, "_donecnt"}, 64'(done_cnt - d0), 64'(expect_done));
        chk({name, "_busy_after"}, 64'(oBUSY), 64'(busy_after));
        chk({name, "_err"}, 64'(oERR), 64'd0);
    endtask

    initial begin
        tbl[0] = '{face: 3'd0, kind: 0, accept: 1'b1};
        tbl[1] = '{face: 3'd5, kind: 1, accept: 1'b1};
        tbl[2] = '{face: 3'd7, kind: 2, accept: 1'b0};
        tbl[3] = '{face: 3'd6, kind: 2, accept: 1'b0};
        tbl[4] = '{face: 3'd2, kind: 2, accept: 1'b1};
        tbl[5] = '{face: 3'd3, kind: 2, accept: 1'b1};
        tbl[6] = '{face: 3'd1, kind: 2, accept: 1'b1};
        tbl[7] = '{face: 3'd4, kind: 2, accept: 1'b1};

        for (int k = 0; k < 54; k++) begin
            exp_r[k] = '0; exp_g[k] = '0; exp_b[k] = '0;
        end

        // Reset state
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_busy", 64'(oBUSY), 64'd0);
        chk("rst_done", 64'(oDONE), 64'd0);
        chk("rst_err", 64'(oERR), 64'd0);
        check_colors("rst_col");
        iRST_N = 1'b1;
        idle(3);

        // Table of capture requests
        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            clear_sums();
            req(tbl[i].face, tbl[i].accept, nm);
            idle(2);
            run_frame(tbl[i].kind, tbl[i].accept, 1'b0, 3'd0);
            wait_done(tbl[i].accept, 1'b0, nm);
            if (tbl[i].accept) commit_face(int'(tbl[i].face));
            check_colors(nm);
            if (i == 0) begin
                chk("uni_R0", 64'(oColor_R[431 -: 8]), 64'h40);
                chk("uni_G8", 64'(oColor_G[431-8*8 -: 8]), 64'h80);
                chk("uni_B8", 64'(oColor_B[431-8*8 -: 8]), 64'hC0);
                chk("uni_R9", 64'(oColor_R[431-8*9 -: 8]), 64'h00);
            end
            if (i == 1) begin
                chk("red_R49", 64'(oColor_R[431-8*49 -: 8]), 64'hFF);
                chk("red_R45", 64'(oColor_R[431-8*45 -: 8]), 64'h00);
                chk("red_R0", 64'(oColor_R[431 -: 8]), 64'h40);
            end
        end

        // Capture arriving mid-frame waits for the next frame; a second request is ignored
        clear_sums();
        run_frame(2, 1'b0, 1'b1, 3'd3);
        wait_done(1'b0, 1'b1, "midreq_first");
        run_frame(2, 1'b1, 1'b1, 3'd0);
        wait_done(1'b1, 1'b0, "midreq_second");
        commit_face(3);
        check_colors("midreq");

        // Reset in ACCUM abandons the capture
        clear_sums();
        req(3'd1, 1'b1, "rstaccum");
        idle(2);
        @(posedge iCLK); #1;
        iFVAL = 1'b1;
        idle(4);
        for (int i = 0; i < 30; i++)
            drive_pix(X0 + OFF + (i % 8), Y0 + OFF + (i / 8), 8'hAA, 8'h55, 8'h33, 1'b1, 1'b0);
        #2;
        iRST_N = 1'b0;
        #1;
        for (int k = 0; k < 54; k++) begin
            exp_r[k] = '0; exp_g[k] = '0; exp_b[k] = '0;
        end
        check_colors("rstaccum_col");
        chk("rstaccum_busy", 64'(oBUSY), 64'd0);
        chk("rstaccum_done", 64'(oDONE), 64'd0);
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        idle(10);
        iFVAL = 1'b0;
        wait_done(1'b0, 1'b0, "rstaccum");
        check_colors("rstaccum_after");

        // Recovery capture after reset
        clear_sums();
        req(3'd2, 1'b1, "recover");
        idle(2);
        run_frame(2, 1'b1, 1'b0, 3'd0);
        wait_done(1'b1, 1'b0, "recover");
        commit_face(2);
        check_colors("recover");

`ifdef SAMPLER_TIMEOUT_EN
        begin
            int first;
            first = 0;
            req(3'd4, 1'b1, "tmo");
            for (int n = 1; n <= (1 << 20) + 5; n++) begin
                @(posedge iCLK); #1;
                if (oERR && first == 0) first = n;
            end
            chk("tmo_latency", 64'(first), 64'(1 << 20));
            chk("tmo_busy", 64'(oBUSY), 64'd0);
            check_colors("tmo_col");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
